// File: rtl/write_buffer_arbiter.sv
// Shares one write buffer among four PE result streams.
// Each PE owns a one-word slot; slots drain in round-robin order.
module write_buffer_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   par_done,
  input  logic [NREQ*DW-1:0] par_data,
  input  logic              ready,
  output logic              write_req,
  output logic              write_in_buffer,
  output logic [DW-1:0]     wdata,
  output logic [1:0]        wsrc,
  output logic [NREQ-1:0]   stall,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state;
  logic [NREQ-1:0]   pending;
  logic [DW-1:0]     slot [NREQ];
  logic [1:0]        sel;
  logic [1:0]        rr_ptr;
  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              found;
  logic [NREQ-1:0]   wr_hit;
  logic              writing;

  assign writing = (state == WRITE);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NREQ; i++)
      wr_hit[i] = writing && (sel == 2'(i));
  end

  // First pending slot at or after rr_ptr, wrapping
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign stall           = pending & ~wr_hit;
  assign write_req       = (state == REQ) || (state == WAIT);
  assign write_in_buffer = writing;
  assign wdata           = writing ? slot[sel] : '0;
  assign wsrc            = writing ? sel : 2'd0;
  assign ack             = wr_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= '0;
      sel      <= 2'd0;
      rr_ptr   <= 2'd0;
      overflow <= '0;
      for (int i = 0; i < NREQ; i++)
        slot[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        // A slot being drained this cycle may be refilled at once
        if (wr_hit[i])
          pending[i] <= par_done[i];
        else if (par_done[i])
          pending[i] <= 1'b1;
        if (par_done[i] && (!pending[i] || wr_hit[i]))
          slot[i] <= par_data[i*DW +: DW];
        if (par_done[i] && pending[i] && !wr_hit[i])
          overflow[i] <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (|pending) begin
            sel   <= pick;
            state <= REQ;
          end
        end
        REQ:   state <= ready ? WRITE : WAIT;
        WAIT:  if (ready) state <= WRITE;
        WRITE: begin
          rr_ptr <= sel + 2'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/write_buffer_arbiter.md
WRITE_BUFFER_ARBITER -- requirements
Module: write_buffer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of processing-element (PE) requesters sharing one write buffer; fixed at 4 (2-bit index).
REQ-002 Parameter DW, default 16, result word width.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 par_done  input  NREQ  one-cycle pulse per PE: result word valid on its par_data slice.
REQ-006 par_data  input  NREQ*DW  packed results; PE i occupies bits [i*DW +: DW].
REQ-007 ready  input  1  write buffer can accept a word this cycle.
REQ-008 write_req  output  1  request to write buffer.
REQ-009 write_in_buffer  output  1  one-cycle write strobe to buffer.
REQ-010 wdata  output  DW  word written; valid when write_in_buffer=1.
REQ-011 wsrc  output  2  index of PE whose word is written; valid with write_in_buffer.
REQ-012 stall  output  NREQ  per-PE stall: PE i must not pulse par_done while stall[i]=1.
REQ-013 ack  output  NREQ  one-cycle pulse: PE i's word entered the buffer.
REQ-014 overflow  output  NREQ  sticky: PE i pulsed par_done while its slot was occupied.

Function
REQ-015 Per PE: one-entry slot = pending[i] bit + DW-bit data register.
REQ-016 par_done[i] with pending[i]=0 -> next edge: pending[i]=1, slot data=par_data slice.
REQ-017 par_done[i] with pending[i]=1 and slot i not written this cycle -> pulse dropped, data unchanged, overflow[i] set.
REQ-018 stall[i] = pending[i] AND NOT (state=WRITE AND sel=i); combinational.
REQ-019 FSM states: IDLE(0), REQ(1), WAIT(2), WRITE(3); 2-bit state register.
REQ-020 IDLE: if any pending, choose sel by round-robin from rr_ptr (first pending at rr_ptr, rr_ptr+1, ... mod 4), register sel, go REQ; else stay IDLE.
REQ-021 REQ: write_req=1; ready=1 -> WRITE; ready=0 -> WAIT.
REQ-022 WAIT: write_req=1; stay until ready=1, then WRITE; no timeout.
REQ-023 WRITE: write_in_buffer=1, wdata=slot[sel] data, wsrc=sel, ack[sel]=1; next edge clears pending[sel], rr_ptr=sel+1 mod 4, go IDLE.
REQ-024 write_req=0 in IDLE and WRITE; write_in_buffer, ack, wsrc, wdata zero outside WRITE.
REQ-025 par_done[sel] during WRITE accepted: pending[sel] stays 1, new data captured; current wdata is old word.
REQ-026 Arrivals during REQ/WAIT/WRITE for other PEs are captured but considered only at next IDLE; sel never changes outside IDLE.
REQ-027 Minimum 3 cycles per write (IDLE->REQ->WRITE); all outputs from state and registers only, except stall.
REQ-028 ready ignored in IDLE and WRITE.

Reset
REQ-029 rst=0 asynchronously forces: state=IDLE, pending=0, slot data=0, sel=0, rr_ptr=0, overflow=0.
REQ-030 During reset all outputs 0; reset mid-transfer abandons the word without write_in_buffer or ack.
REQ-031 First posedge after rst rises behaves as IDLE with empty slots.

Verification
REQ-032 Single: par_done=0001, par_data[15:0]=0xA5A5, ready=1 -> write_req cycles 2, write_in_buffer cycle 3 with wdata=0xA5A5, wsrc=0, ack=0001; stall[0]=1 from capture until WRITE.
REQ-033 Fairness: par_done=1111 once, ready=1 -> writes in order wsrc 0,1,2,3, 3 cycles apart, rr_ptr ends 0.
REQ-034 Backpressure: one pending, ready=0 for 5 cycles -> REQ then WAIT x5 with write_req=1, no write; ready=1 -> WRITE next cycle.
REQ-035 Overflow: par_done[2] twice, ready=0 -> second word dropped, overflow=0100 sticky, written word is first.
REQ-036 Same-cycle refill: par_done[1] during its WRITE -> old word written, pending[1] stays 1, new word written next round, overflow=0.
REQ-037 Reset in WAIT: rst=0 -> outputs 0 immediately; after release, no write occurs without new par_done.
